icache: RTL and testbench

// - Direct-mapped, read-only instruction cache between the fetch stage and the 64-bit system bus.
// - Fetch presents pc; the cache returns the 32-bit instruction at pc on instr_reg with a 1-cycle data_ack pulse.
// - On a miss it fetches the whole 64-byte line as an 8-beat bus burst, then replays the lookup.

---
 rtl/icache.sv | 132 +++++++++++++
 tb/tb_icache.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 64 B lines, 8-beat fill.
// Define ICACHE_TRACE_EN for simulation-only miss/fill trace messages.
module icache #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int NUM_LINES      = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               pc,
   input  logic [63:0]               stackptr,
   output logic                      bus_reqcyc,
   output logic [63:0]               bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   output logic                      bus_respack,
   output logic                      data_ack,
   output logic [31:0]               instr_reg
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 58 - IDX_W;
   localparam logic [BUS_TAG_WIDTH-1:0] READ = BUS_TAG_WIDTH'(13'h1100);

   typedef enum logic [1:0] {LOOKUP, ACK, REQ, FILL} state_t;

   state_t state, state_n;

   logic [NUM_LINES-1:0]      valid;
   logic [TAG_W-1:0]          tags [NUM_LINES];
   logic [BUS_DATA_WIDTH-1:0] mem  [NUM_LINES*8];

   logic [57:0]      line_addr;
   logic [2:0]       beat;
   logic [IDX_W-1:0] pc_idx;
   logic [TAG_W-1:0] pc_tag;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             hit;
   logic             last_beat;
   logic [BUS_DATA_WIDTH-1:0] rd_word;
   logic             unused_ok;

   assign pc_idx    = pc[6 +: IDX_W];
   assign pc_tag    = pc[63 -: TAG_W];
   assign fill_idx  = line_addr[IDX_W-1:0];
   assign fill_tag  = line_addr[57 -: TAG_W];
   assign hit       = valid[pc_idx] && (tags[pc_idx] == pc_tag);
   assign rd_word   = mem[{pc_idx, pc[5:3]}];
   assign last_beat = bus_respack && (beat == 3'd7);
   assign unused_ok = ^{stackptr, pc[1:0]};

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= LOOKUP;
      else        state <= state_n;
   end

   // Next-state and bus/handshake outputs
   always_comb begin
      state_n     = state;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      data_ack    = 1'b0;
      unique case (state)
         LOOKUP: state_n = hit ? ACK : REQ;
         ACK: begin
            data_ack = 1'b1;
            state_n  = LOOKUP;
         end
         REQ: begin
            bus_reqcyc = 1'b1;
            bus_req    = {line_addr, 6'b0};
            bus_reqtag = READ;
            if (bus_reqack) state_n = FILL;
         end
         FILL: begin
            bus_respack = bus_respcyc && (bus_resptag == READ);
            if (bus_respack && beat == 3'd7) state_n = LOOKUP;
         end
         default: state_n = LOOKUP;
      endcase
   end

   // Valid bits, miss address latch, beat counter, instruction output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid     <= '0;
         line_addr <= '0;
         beat      <= '0;
         instr_reg <= '0;
      end else begin
         if (state == LOOKUP) begin
            if (hit) begin
               instr_reg <= pc[2] ? rd_word[63:32] : rd_word[31:0];
            end else begin
               line_addr      <= pc[63:6];
               valid[pc_idx]  <= 1'b0;
            end
         end
         if (state == REQ && bus_reqack) beat <= 3'd0;
         if (state == FILL && bus_respack) begin
            beat <= beat + 3'd1;
            if (last_beat) valid[fill_idx] <= 1'b1;
         end
      end
   end

   // Line storage and tags; only written by acked fill beats
   always_ff @(posedge clk) begin
      if (state == FILL && bus_respack) begin
         mem[{fill_idx, beat}] <= bus_resp;
         if (last_beat) tags[fill_idx] <= fill_tag;
      end
   end

`ifdef ICACHE_TRACE_EN
   // Simulation trace of misses and completed fills
   always @(posedge clk) begin
      if (reset && state == LOOKUP && !hit)
         $display("ICACHE MISS %x", {pc[63:6], 6'b0});
      if (reset && state == FILL && last_beat)
         $display("ICACHE FILL %x", {line_addr, 6'b0});
   end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflict,
// bus stall, wrong-tag beat and reset during a fill.
module tb_icache;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] pc = '0;
   logic [63:0] stackptr = '0;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack = 1'b0;
   logic        bus_respcyc = 1'b0;
   logic [63:0] bus_resp = '0;
   logic [12:0] bus_resptag = '0;
   logic        bus_respack;
   logic        data_ack;
   logic [31:0] instr_reg;

   int errors = 0;
   int checks = 0;

   icache dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .stackptr   (stackptr),
      .bus_reqcyc (bus_reqcyc),
      .bus_req    (bus_req),
      .bus_reqtag (bus_reqtag),
      .bus_reqack (bus_reqack),
      .bus_respcyc(bus_respcyc),
      .bus_resp   (bus_resp),
      .bus_resptag(bus_resptag),
      .bus_respack(bus_respack),
      .data_ack   (data_ack),
      .instr_reg  (instr_reg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [5];

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] beat(input int s, input int k);
      return {16'hAAAA, 8'(s), 8'(k), 16'h5555, 8'(s), 8'(k)};
   endfunction

   function automatic logic [31:0] exp_instr(input int s,
                                             input logic [63:0] a);
      logic [63:0] b;
      b = beat(s, int'(a[5:3]));
      return a[2] ? b[63:32] : b[31:0];
   endfunction

   task automatic check_zero(input string nm);
      check({nm, "_reqcyc"}, 64'(bus_reqcyc), 64'd0);
      check({nm, "_req"}, bus_req, 64'd0);
      check({nm, "_reqtag"}, 64'(bus_reqtag), 64'd0);
      check({nm, "_respack"}, 64'(bus_respack), 64'd0);
      check({nm, "_data_ack"}, 64'(data_ack), 64'd0);
      check({nm, "_instr"}, 64'(instr_reg), 64'd0);
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_reqcyc && n < 8);
      check("req_valid", 64'(bus_reqcyc), 64'd1);
   endtask

   task automatic miss_fill(input logic [63:0] a, input int s,
                            input int stall, input int bad);
      int n;
      logic [63:0] req;
      req = {a[63:6], 6'b0};
      pc = a;
      wait_req();
      check("req_addr", bus_req, req);
      check("req_tag", 64'(bus_reqtag), 64'h1100);
      for (int i = 0; i < stall; i++) begin
         pc = 64'h0000_7700_0000_0040;
         @(negedge clk);
         check("stall_reqcyc", 64'(bus_reqcyc), 64'd1);
         check("stall_addr", bus_req, req);
         check("stall_tag", 64'(bus_reqtag), 64'h1100);
      end
      pc = a;
      bus_reqack = 1'b1;
      @(negedge clk);
      bus_reqack = 1'b0;
      check("req_drop", 64'(bus_reqcyc), 64'd0);
      for (int k = 0; k < 8; k++) begin
         if (k == bad) begin
            bus_respcyc = 1'b1;
            bus_resptag = 13'h0100;
            bus_resp    = 64'hBAD0_BAD0_BAD0_BAD0;
            #1 check("badtag_ack", 64'(bus_respack), 64'd0);
            @(negedge clk);
         end
         bus_respcyc = 1'b1;
         bus_resptag = 13'h1100;
         bus_resp    = beat(s, k);
         #1 check("beat_ack", 64'(bus_respack), 64'd1);
         check("fill_no_ack", 64'(data_ack), 64'd0);
         @(negedge clk);
      end
      bus_respcyc = 1'b0;
      bus_resptag = '0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!data_ack && n < 6);
      check("fill_ack", 64'(data_ack), 64'd1);
      check("fill_lat", 64'(n), 64'd1);
      check("fill_instr", 64'(instr_reg), 64'(exp_instr(s, a)));
   endtask

   task automatic hit(input logic [63:0] a, input logic [31:0] e);
      int n;
      logic seen;
      pc = a;
      n = 0;
      seen = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (bus_reqcyc) seen = 1'b1;
      end while (!data_ack && n < 6);
      check("hit_lat", 64'(n), 64'd2);
      check("hit_noreq", 64'(seen), 64'd0);
      check("hit_instr", 64'(instr_reg), 64'(e));
   endtask

   initial begin
      vt[0] = '{64'h1020, 32'h5555_0104};
      vt[1] = '{64'h1024, 32'hAAAA_0104};
      vt[2] = '{64'h1003, 32'h5555_0100};
      vt[3] = '{64'h103C, 32'hAAAA_0107};
      vt[4] = '{64'h1008, 32'h5555_0101};

      repeat (3) @(negedge clk);
      check_zero("rst");
      reset = 1'b1;

      miss_fill(64'h1000, 1, 0, -1);
      check("cold_b0", 64'(instr_reg), 64'h5555_0100);

      for (int i = 0; i < 5; i++) hit(vt[i].pc, vt[i].exp);

      miss_fill(64'h2000, 2, 0, -1);
      hit(64'h2014, 32'hAAAA_0202);
      miss_fill(64'h1000, 3, 0, -1);
      hit(64'h1038, 32'h5555_0307);

      miss_fill(64'h3050, 4, 5, 2);
      check("badtag_word", 64'(instr_reg), 64'h5555_0402);
      hit(64'h1000, 32'h5555_0300);

      pc = 64'h4000;
      wait_req();
      bus_reqack = 1'b1;
      @(negedge clk);
      bus_reqack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus_respcyc = 1'b1;
         bus_resptag = 13'h1100;
         bus_resp    = beat(7, k);
         @(negedge clk);
      end
      bus_resp = beat(7, 4);
      reset = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk);
      check("midrst_respack2", 64'(bus_respack), 64'd0);
      bus_respcyc = 1'b0;
      bus_resptag = '0;
      reset = 1'b1;
      miss_fill(64'h1000, 5, 0, -1);
      hit(64'h1024, 32'hAAAA_0504);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
